// File: rtl/axil_arb_2to1.sv
// Two-master to one-slave AXI4-Lite arbiter; write and read paths arbitrated independently, one outstanding txn per path.
// Latency: grant registered one cycle after the request is seen in IDLE; payload and handshakes then pass combinationally.
// Backpressure: readies/valids pass straight through to the granted master only; the others see 0 until the grant returns.
// Build option AXIL_ARB_RR_EN: round-robin tie-break on last-grant pointers; undefined gives fixed priority to master 0.
module axil_arb_2to1 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [2*ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic [5:0]                s_axil_awprot,
    input  logic [1:0]                s_axil_awvalid,
    output logic [1:0]                s_axil_awready,
    input  logic [2*DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [2*STRB_WIDTH-1:0]   s_axil_wstrb,
    input  logic [1:0]                s_axil_wvalid,
    output logic [1:0]                s_axil_wready,
    output logic [3:0]                s_axil_bresp,
    output logic [1:0]                s_axil_bvalid,
    input  logic [1:0]                s_axil_bready,
    input  logic [2*ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic [5:0]                s_axil_arprot,
    input  logic [1:0]                s_axil_arvalid,
    output logic [1:0]                s_axil_arready,
    output logic [2*DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [3:0]                s_axil_rresp,
    output logic [1:0]                s_axil_rvalid,
    input  logic [1:0]                s_axil_rready,

    output logic [ADDR_WIDTH-1:0]     m_axil_awaddr,
    output logic [2:0]                m_axil_awprot,
    output logic                      m_axil_awvalid,
    input  logic                      m_axil_awready,
    output logic [DATA_WIDTH-1:0]     m_axil_wdata,
    output logic [STRB_WIDTH-1:0]     m_axil_wstrb,
    output logic                      m_axil_wvalid,
    input  logic                      m_axil_wready,
    input  logic [1:0]                m_axil_bresp,
    input  logic                      m_axil_bvalid,
    output logic                      m_axil_bready,
    output logic [ADDR_WIDTH-1:0]     m_axil_araddr,
    output logic [2:0]                m_axil_arprot,
    output logic                      m_axil_arvalid,
    input  logic                      m_axil_arready,
    input  logic [DATA_WIDTH-1:0]     m_axil_rdata,
    input  logic [1:0]                m_axil_rresp,
    input  logic                      m_axil_rvalid,
    output logic                      m_axil_rready
);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_FWD  = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_FWD  = 2'd1;
    localparam logic [1:0] R_RESP = 2'd2;

    logic [1:0] w_state;
    logic       wg;
    logic       aw_done;
    logic       w_done;
    logic [1:0] r_state;
    logic       rg;

    logic       w_pick;
    logic       r_pick;
    logic       aw_hs;
    logic       w_hs;
    logic       b_hs;
    logic       ar_hs;
    logic       r_hs;

    assign aw_hs = m_axil_awvalid & m_axil_awready;
    assign w_hs  = m_axil_wvalid & m_axil_wready;
    assign b_hs  = m_axil_bvalid & m_axil_bready;
    assign ar_hs = m_axil_arvalid & m_axil_arready;
    assign r_hs  = m_axil_rvalid & m_axil_rready;

`ifdef AXIL_ARB_RR_EN
    logic w_ptr;
    logic r_ptr;

    // Tie goes to the master that was not granted last; a lone requester always wins.
    always_comb begin
        w_pick = s_axil_awvalid[1];
        r_pick = s_axil_arvalid[1];
        if (&s_axil_awvalid) begin
            w_pick = ~w_ptr;
        end
        if (&s_axil_arvalid) begin
            r_pick = ~r_ptr;
        end
    end

    // Last-grant pointers advance when a path's response handshakes; reset to 1 so master 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr <= 1'b1;
            r_ptr <= 1'b1;
        end else begin
            if (w_state == W_RESP && b_hs) begin
                w_ptr <= wg;
            end
            if (r_state == R_RESP && r_hs) begin
                r_ptr <= rg;
            end
        end
    end
`else
    // Fixed priority: master 1 is picked only when it requests alone.
    always_comb begin
        w_pick = (s_axil_awvalid == 2'b10);
        r_pick = (s_axil_arvalid == 2'b10);
    end
`endif

    // Write path: grant on AW request, forward AW/W in any order, hold grant until B handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            wg      <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (|s_axil_awvalid) begin
                        wg      <= w_pick;
                        w_state <= W_FWD;
                    end
                end
                W_FWD: begin
                    if (aw_hs) begin
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        w_done <= 1'b1;
                    end
                    if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                        w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (b_hs) begin
                        w_state <= W_IDLE;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                end
            endcase
        end
    end

    // Read path: grant on AR request, forward AR, hold grant until R handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            rg      <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (|s_axil_arvalid) begin
                        rg      <= r_pick;
                        r_state <= R_FWD;
                    end
                end
                R_FWD: begin
                    if (ar_hs) begin
                        r_state <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (r_hs) begin
                        r_state <= R_IDLE;
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

    // Write handshake steering: only the granted slot sees ready/valid; done flags stop a second AW or W.
    always_comb begin
        s_axil_awready = 2'b00;
        s_axil_wready  = 2'b00;
        s_axil_bvalid  = 2'b00;
        m_axil_awvalid = 1'b0;
        m_axil_wvalid  = 1'b0;
        m_axil_bready  = 1'b0;
        if (w_state == W_FWD) begin
            m_axil_awvalid     = s_axil_awvalid[wg] & ~aw_done;
            s_axil_awready[wg] = m_axil_awready & ~aw_done;
            m_axil_wvalid      = s_axil_wvalid[wg] & ~w_done;
            s_axil_wready[wg]  = m_axil_wready & ~w_done;
        end
        if (w_state == W_RESP) begin
            s_axil_bvalid[wg] = m_axil_bvalid;
            m_axil_bready     = s_axil_bready[wg];
        end
    end

    // Read handshake steering, same scheme as the write path.
    always_comb begin
        s_axil_arready = 2'b00;
        s_axil_rvalid  = 2'b00;
        m_axil_arvalid = 1'b0;
        m_axil_rready  = 1'b0;
        if (r_state == R_FWD) begin
            m_axil_arvalid     = s_axil_arvalid[rg];
            s_axil_arready[rg] = m_axil_arready;
        end
        if (r_state == R_RESP) begin
            s_axil_rvalid[rg] = m_axil_rvalid;
            m_axil_rready     = s_axil_rready[rg];
        end
    end

    // Payload muxes follow the registered grant; responses fan out to both slots, gated only by valid.
    assign m_axil_awaddr = wg ? s_axil_awaddr[ADDR_WIDTH +: ADDR_WIDTH] : s_axil_awaddr[0 +: ADDR_WIDTH];
    assign m_axil_awprot = wg ? s_axil_awprot[5:3] : s_axil_awprot[2:0];
    assign m_axil_wdata  = wg ? s_axil_wdata[DATA_WIDTH +: DATA_WIDTH] : s_axil_wdata[0 +: DATA_WIDTH];
    assign m_axil_wstrb  = wg ? s_axil_wstrb[STRB_WIDTH +: STRB_WIDTH] : s_axil_wstrb[0 +: STRB_WIDTH];
    assign m_axil_araddr = rg ? s_axil_araddr[ADDR_WIDTH +: ADDR_WIDTH] : s_axil_araddr[0 +: ADDR_WIDTH];
    assign m_axil_arprot = rg ? s_axil_arprot[5:3] : s_axil_arprot[2:0];

    assign s_axil_bresp  = {2{m_axil_bresp}};
    assign s_axil_rdata  = {2{m_axil_rdata}};
    assign s_axil_rresp  = {2{m_axil_rresp}};

endmodule

// File: tb/tb_axil_arb_2to1.sv
// Directed bench for axil_arb_2to1: table of write transactions plus hand-written read, concurrency and reset sequences.
// Inputs change 1 ns after the rising edge; outputs are sampled 2 ns after it.
// Expected grant order on ties follows AXIL_ARB_RR_EN when the same define is given to the bench.
module tb_axil_arb_2to1;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SW = 4;

`ifdef AXIL_ARB_RR_EN
    localparam int TIE_B = 1;   // second of two back-to-back ties goes to master 1
`else
    localparam int TIE_B = 0;   // fixed priority: master 0 keeps winning
`endif

    localparam logic [15:0] A0 = 16'h0040;
    localparam logic [15:0] A1 = 16'h0010;
    localparam logic [31:0] D0 = 32'h1111_1111;
    localparam logic [31:0] D1 = 32'hDEAD_BEEF;
    localparam logic [3:0]  S0 = 4'h3;
    localparam logic [3:0]  S1 = 4'hF;

    logic              clk = 1'b0;
    logic              rst;
    logic [2*AW-1:0]   s_axil_awaddr;
    logic [5:0]        s_axil_awprot;
    logic [1:0]        s_axil_awvalid;
    logic [1:0]        s_axil_awready;
    logic [2*DW-1:0]   s_axil_wdata;
    logic [2*SW-1:0]   s_axil_wstrb;
    logic [1:0]        s_axil_wvalid;
    logic [1:0]        s_axil_wready;
    logic [3:0]        s_axil_bresp;
    logic [1:0]        s_axil_bvalid;
    logic [1:0]        s_axil_bready;
    logic [2*AW-1:0]   s_axil_araddr;
    logic [5:0]        s_axil_arprot;
    logic [1:0]        s_axil_arvalid;
    logic [1:0]        s_axil_arready;
    logic [2*DW-1:0]   s_axil_rdata;
    logic [3:0]        s_axil_rresp;
    logic [1:0]        s_axil_rvalid;
    logic [1:0]        s_axil_rready;
    logic [AW-1:0]     m_axil_awaddr;
    logic [2:0]        m_axil_awprot;
    logic              m_axil_awvalid;
    logic              m_axil_awready;
    logic [DW-1:0]     m_axil_wdata;
    logic [SW-1:0]     m_axil_wstrb;
    logic              m_axil_wvalid;
    logic              m_axil_wready;
    logic [1:0]        m_axil_bresp;
    logic              m_axil_bvalid;
    logic              m_axil_bready;
    logic [AW-1:0]     m_axil_araddr;
    logic [2:0]        m_axil_arprot;
    logic              m_axil_arvalid;
    logic              m_axil_arready;
    logic [DW-1:0]     m_axil_rdata;
    logic [1:0]        m_axil_rresp;
    logic              m_axil_rvalid;
    logic              m_axil_rready;

    axil_arb_2to1 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
        .clk(clk), .rst(rst),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req;
        int         aw_at;
        int         w_at;
        logic [1:0] bresp;
        int         gnt;
        int         exp_aw_hs;
        int         exp_w_hs;
        int         exp_b_hs;
    } vec_t;

    vec_t vecs [8];

    int n_checks = 0;
    int n_err    = 0;

    int          r_aw_hs, r_w_hs, r_b_hs, r_fwd, r_nb;
    bit          r_leak;
    logic [1:0]  r_bwho;
    logic [3:0]  r_bresp;
    logic [15:0] r_awaddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [9:0]  r_idle;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One write transaction with a simple target: AW/W ready from cycle aw_at/w_at, B one cycle after both complete.
    task automatic write_txn(input logic [1:0] req, input int aw_at, input int w_at,
                             input logic [1:0] bresp, input int gnt);
        logic [1:0] awv;
        logic [1:0] wv;
        logic [1:0] gmask;
        bit aw_d;
        bit w_d;
        bit b_on;
        awv = req; wv = req;
        gmask = (gnt == 1) ? 2'b10 : 2'b01;
        aw_d = 0; w_d = 0; b_on = 0;
        r_aw_hs = -1; r_w_hs = -1; r_b_hs = -1; r_fwd = -1; r_nb = 0; r_leak = 0;
        r_bwho = '0; r_bresp = '0; r_awaddr = '0; r_wdata = '0; r_wstrb = '0;
        s_axil_bready = 2'b11;
        m_axil_bresp  = bresp;
        for (int c = 0; c < 40; c++) begin
            s_axil_awvalid = awv;
            s_axil_wvalid  = wv;
            m_axil_awready = !aw_d && (c >= aw_at);
            m_axil_wready  = !w_d && (c >= w_at);
            m_axil_bvalid  = b_on;
            #1;
            if (c == 0 && (m_axil_awvalid || m_axil_wvalid || (|s_axil_awready) || (|s_axil_wready)))
                r_leak = 1;
            if (((s_axil_awready | s_axil_wready | s_axil_bvalid) & ~gmask) != 2'b00)
                r_leak = 1;
            if (m_axil_awvalid && r_fwd < 0) r_fwd = c;
            if (m_axil_awvalid && m_axil_awready) begin
                aw_d = 1; r_aw_hs = c; r_awaddr = m_axil_awaddr;
            end
            if (m_axil_wvalid && m_axil_wready) begin
                w_d = 1; r_w_hs = c; r_wdata = m_axil_wdata; r_wstrb = m_axil_wstrb;
            end
            if ((s_axil_bvalid & s_axil_bready) != 2'b00) begin
                r_nb++; r_bwho = r_bwho | s_axil_bvalid; r_bresp = s_axil_bresp;
            end
            if (m_axil_bvalid && m_axil_bready) begin
                r_b_hs = c; b_on = 0;
            end else if (aw_d && w_d && r_b_hs < 0) begin
                b_on = 1;
            end
            awv = awv & ~s_axil_awready;
            wv  = wv & ~s_axil_wready;
            step();
            if (r_b_hs >= 0) break;
        end
        s_axil_awvalid = 2'b00; s_axil_wvalid = 2'b00;
        m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b0;
        #1;
        r_idle = {m_axil_awvalid, m_axil_wvalid, m_axil_bready, s_axil_awready, s_axil_wready, s_axil_bvalid, 1'b0};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //            req    aw w  bresp  gnt    aw_hs w_hs b_hs
        vecs[0] = '{2'b11, 1, 1, 2'b00, 0,     1, 1, 2};
        vecs[1] = '{2'b11, 1, 1, 2'b00, TIE_B, 1, 1, 2};
        vecs[2] = '{2'b11, 1, 1, 2'b00, 0,     1, 1, 2};
        vecs[3] = '{2'b11, 1, 1, 2'b00, TIE_B, 1, 1, 2};
        vecs[4] = '{2'b10, 1, 1, 2'b00, 1,     1, 1, 2};
        vecs[5] = '{2'b10, 4, 1, 2'b10, 1,     4, 1, 5};
        vecs[6] = '{2'b01, 1, 3, 2'b01, 0,     1, 3, 4};
        vecs[7] = '{2'b11, 2, 2, 2'b11, TIE_B, 2, 2, 3};

        s_axil_awaddr = {A1, A0};
        s_axil_awprot = 6'o21;
        s_axil_wdata  = {D1, D0};
        s_axil_wstrb  = {S1, S0};
        s_axil_araddr = '0;
        s_axil_arprot = 6'o43;
        m_axil_bresp  = 2'b00;
        m_axil_rdata  = '0;
        m_axil_rresp  = 2'b00;

        // Reset with every request and target handshake asserted: all gated outputs must stay 0.
        rst = 1'b1;
        s_axil_awvalid = 2'b11; s_axil_wvalid = 2'b11; s_axil_bready = 2'b11;
        s_axil_arvalid = 2'b11; s_axil_rready = 2'b11;
        m_axil_awready = 1'b1; m_axil_wready = 1'b1; m_axil_bvalid = 1'b1;
        m_axil_arready = 1'b1; m_axil_rvalid = 1'b1;
        step(); step();
        #1;
        chk("rst_m_side", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready}, '0);
        chk("rst_s_side", {s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid}, '0);
        s_axil_awvalid = 2'b00; s_axil_wvalid = 2'b00; s_axil_bready = 2'b00;
        s_axil_arvalid = 2'b00; s_axil_rready = 2'b00;
        m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_bvalid = 1'b0;
        m_axil_arready = 1'b0; m_axil_rvalid = 1'b0;
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            write_txn(vecs[i].req, vecs[i].aw_at, vecs[i].w_at, vecs[i].bresp, vecs[i].gnt);
            chk($sformatf("v%0d_fwd_cycle", i), r_fwd, 1);
            chk($sformatf("v%0d_awaddr", i), r_awaddr, (vecs[i].gnt == 1) ? A1 : A0);
            chk($sformatf("v%0d_wdata", i), r_wdata, (vecs[i].gnt == 1) ? D1 : D0);
            chk($sformatf("v%0d_wstrb", i), r_wstrb, (vecs[i].gnt == 1) ? S1 : S0);
            chk($sformatf("v%0d_aw_hs", i), r_aw_hs, vecs[i].exp_aw_hs);
            chk($sformatf("v%0d_w_hs", i), r_w_hs, vecs[i].exp_w_hs);
            chk($sformatf("v%0d_b_hs", i), r_b_hs, vecs[i].exp_b_hs);
            chk($sformatf("v%0d_bvalid_slot", i), r_bwho, (vecs[i].gnt == 1) ? 2'b10 : 2'b01);
            chk($sformatf("v%0d_bresp", i), r_bresp, {vecs[i].bresp, vecs[i].bresp});
            chk($sformatf("v%0d_b_count", i), r_nb, 1);
            chk($sformatf("v%0d_no_leak", i), r_leak, 0);
            chk($sformatf("v%0d_idle_after", i), r_idle, '0);
        end

        // Concurrent: master 0 reads 0x0020 while master 1 writes 0x0020.
        step();
        s_axil_araddr = {16'h0000, 16'h0020}; s_axil_arvalid = 2'b01;
        s_axil_awaddr = {16'h0020, A0}; s_axil_awvalid = 2'b10; s_axil_wvalid = 2'b10;
        m_axil_awready = 1'b1; m_axil_wready = 1'b1; m_axil_arready = 1'b1;
        s_axil_bready = 2'b11; s_axil_rready = 2'b11;
        m_axil_rdata = 32'hCAFE_F00D; m_axil_rresp = 2'b10; m_axil_bresp = 2'b00;
        step();
        #1;
        chk("cc_m_valids", {m_axil_arvalid, m_axil_awvalid, m_axil_wvalid}, 3'b111);
        chk("cc_addrs", {m_axil_araddr, m_axil_awaddr}, {16'h0020, 16'h0020});
        chk("cc_s_readies", {s_axil_arready, s_axil_awready, s_axil_wready}, 6'b01_10_10);
        step();
        s_axil_arvalid = 2'b00; s_axil_awvalid = 2'b00; s_axil_wvalid = 2'b00;
        m_axil_awready = 1'b0; m_axil_wready = 1'b0; m_axil_arready = 1'b0;
        m_axil_bvalid = 1'b1; m_axil_rvalid = 1'b1;
        #1;
        chk("cc_rvalid_slot", s_axil_rvalid, 2'b01);
        chk("cc_bvalid_slot", s_axil_bvalid, 2'b10);
        chk("cc_rdata", s_axil_rdata, {32'hCAFE_F00D, 32'hCAFE_F00D});
        chk("cc_rresp", s_axil_rresp, 4'b1010);
        chk("cc_resp_readies", {m_axil_rready, m_axil_bready}, 2'b11);
        step();
        m_axil_bvalid = 1'b0; m_axil_rvalid = 1'b0;
        s_axil_awaddr = {A1, A0};
        #1;
        chk("cc_idle", {s_axil_rvalid, s_axil_bvalid, m_axil_arvalid, m_axil_awvalid}, '0);

        // Back-pressure: master 1 holds rready low for 5 cycles; master 0's AR must wait.
        step();
        s_axil_araddr = {16'h0030, 16'h0050}; s_axil_arvalid = 2'b10;
        m_axil_arready = 1'b1; s_axil_rready = 2'b00; m_axil_rdata = 32'h1234_5678; m_axil_rresp = 2'b00;
        step();
        #1;
        chk("bp_ar_fwd", {m_axil_arvalid, m_axil_araddr, s_axil_arready}, {1'b1, 16'h0030, 2'b10});
        step();
        s_axil_arvalid = 2'b01; m_axil_rvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp_rready_low_%0d", k), m_axil_rready, 1'b0);
            chk($sformatf("bp_held_%0d", k), {s_axil_rvalid, s_axil_rdata}, {2'b10, 32'h1234_5678, 32'h1234_5678});
            chk($sformatf("bp_no_new_ar_%0d", k), {m_axil_arvalid, s_axil_arready}, 3'b000);
            step();
        end
        s_axil_rready = 2'b10;
        #1;
        chk("bp_r_hs", {m_axil_rready, s_axil_rvalid}, 3'b1_10);
        step();
        m_axil_rvalid = 1'b0; s_axil_rready = 2'b00;
        #1;
        chk("bp_idle_gap", {m_axil_arvalid, s_axil_arready}, 3'b000);
        step();
        #1;
        chk("bp_next_ar", {m_axil_arvalid, m_axil_araddr, s_axil_arready}, {1'b1, 16'h0050, 2'b01});
        step();
        s_axil_arvalid = 2'b00; m_axil_arready = 1'b0; m_axil_rvalid = 1'b1; s_axil_rready = 2'b01;
        #1;
        chk("bp_next_r", s_axil_rvalid, 2'b01);
        step();
        m_axil_rvalid = 1'b0; s_axil_rready = 2'b00;

        // Leave the write pointer on master 0 so the post-reset tie exposes a pointer that failed to reset.
        write_txn(2'b01, 1, 1, 2'b00, 0);
        chk("pre_rst_bvalid_slot", r_bwho, 2'b01);

        // Reset during W_RESP of a master 1 write, then both masters request.
        step();
        s_axil_awvalid = 2'b10; s_axil_wvalid = 2'b10;
        m_axil_awready = 1'b1; m_axil_wready = 1'b1; s_axil_bready = 2'b11; m_axil_bvalid = 1'b0;
        step();
        #1;
        chk("rs_fwd_m1", {m_axil_awvalid, m_axil_awaddr}, {1'b1, A1});
        step();
        s_axil_awvalid = 2'b11; s_axil_wvalid = 2'b11;
        #1;
        chk("rs_in_wresp", {m_axil_bready, m_axil_awvalid}, 2'b10);
        rst = 1'b1;
        step();
        m_axil_bvalid = 1'b1;
        #1;
        chk("rs_m_side", {m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready}, '0);
        chk("rs_s_side", {s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid}, '0);
        rst = 1'b0;
        step();
        m_axil_bvalid = 1'b0;
        #1;
        chk("rs_regrant_m0", {m_axil_awvalid, m_axil_awaddr, s_axil_awready}, {1'b1, A0, 2'b01});
        step();
        s_axil_awvalid = 2'b10; s_axil_wvalid = 2'b10; m_axil_bvalid = 1'b1;
        m_axil_awready = 1'b0; m_axil_wready = 1'b0;
        #1;
        chk("rs_b_to_m0", s_axil_bvalid, 2'b01);
        step();
        s_axil_awvalid = 2'b00; s_axil_wvalid = 2'b00; m_axil_bvalid = 1'b0; s_axil_bready = 2'b00;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/axil_arb_2to1.md
# axil_arb_2to1

Two-master to one-slave AXI4-Lite arbiter that shares a single AXI4-Lite target (typically one port of a block RAM or a register file) between two requesters on one clock. Write and read paths are arbitrated independently. Each path carries at most one outstanding transaction, and each path grants one master for a full address-data-response sequence. Payload is forwarded combinationally once a grant is held; only the grant decision is registered.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width in bits
- ADDR_WIDTH, 16, address bus width in bits
- STRB_WIDTH, DATA_WIDTH/8, wstrb width

Ports. Master-side vectors are concatenated; master n occupies slice [n*W +: W].
- clk  in  1  single clock; all logic is on its rising edge
- rst  in  1  reset; synchronous, active-high
- s_axil_awaddr/awprot/awvalid  in  2*ADDR_WIDTH / 2*3 / 2  write address from masters; s_axil_awready  out  2
- s_axil_wdata/wstrb/wvalid  in  2*DATA_WIDTH / 2*STRB_WIDTH / 2  write data; s_axil_wready  out  2
- s_axil_bresp/bvalid  out  2*2 / 2  write response; s_axil_bready  in  2
- s_axil_araddr/arprot/arvalid  in  2*ADDR_WIDTH / 2*3 / 2  read address; s_axil_arready  out  2
- s_axil_rdata/rresp/rvalid  out  2*DATA_WIDTH / 2*2 / 2  read data; s_axil_rready  in  2
- m_axil_awaddr/awprot/awvalid  out  ADDR_WIDTH / 3 / 1  write address to target; m_axil_awready  in  1
- m_axil_wdata/wstrb/wvalid  out  DATA_WIDTH / STRB_WIDTH / 1  write data to target; m_axil_wready  in  1
- m_axil_bresp/bvalid  in  2 / 1  write response from target; m_axil_bready  out  1
- m_axil_araddr/arprot/arvalid  out  ADDR_WIDTH / 3 / 1  read address to target; m_axil_arready  in  1
- m_axil_rdata/rresp/rvalid  in  DATA_WIDTH / 2 / 1  read data from target; m_axil_rready  out  1

## Operation
- Write FSM states and transitions:
  - W_IDLE: on any s_axil_awvalid bit, register grant wg and go to W_FWD.
  - W_FWD: forward AW and W to the target. When both have handshaken, go to W_RESP.
  - W_RESP: forward B. On the B handshake, go to W_IDLE and update the write pointer.
- Read FSM states and transitions:
  - R_IDLE: on any s_axil_arvalid bit, register grant rg and go to R_FWD.
  - R_FWD: forward AR. On the AR handshake, go to R_RESP.
  - R_RESP: forward R. On the R handshake, go to R_IDLE and update the read pointer.
- Write forwarding in W_FWD:
  - m_axil_awvalid = s_axil_awvalid[wg] & !aw_done; s_axil_awready[wg] = m_axil_awready & !aw_done.
  - W channel uses the same scheme with w_done.
  - aw_done and w_done are set on their handshakes and cleared on entry to W_IDLE. AW and W may complete in either order or in the same cycle.
- Response forwarding in W_RESP and R_RESP: s_axil_bvalid[wg] = m_axil_bvalid and m_axil_bready = s_axil_bready[wg]. R is analogous with rg.
- Response payload: bresp, rdata and rresp are replicated to both master slots; only the valid bit is gated by the grant.
- Non-granted masters, and all masters in IDLE: every ready and every valid driven to them is 0.
- m_axil address, data and strb outputs always carry the granted master's payload. Their value is don't-care while the corresponding valid is 0.
- Arbitration: a last-grant pointer per path; the master that is not the pointer wins when both request. A lone requester wins unconditionally.
- Read and write paths never block each other. A simultaneous read and write to the same address is resolved by the target.

## Timing
- Reset: FSMs go to IDLE and both pointers go to 1, so master 0 wins the first tie. All s_axil valid/ready bits and m_axil_awvalid, wvalid, arvalid, bready and rready are 0 from the first cycle after rst is sampled high.
- Grant latency: a request seen in IDLE in cycle N makes m_axil_*valid visible in cycle N+1. The forward path is 0-cycle combinational.
- Back-to-back: after a response handshake in cycle N, the path is in IDLE in N+1 and can forward again in N+2. The sustained rate is therefore at best one transaction per 3 cycles per path.
- Valid requests from masters must stay asserted until their handshake. A grant is never revoked before the response handshake.
- Reset mid-transaction abandons the transaction. The target must be reset in the same cycle.

## Configuration
- AXIL_ARB_RR_EN defined: round-robin arbitration using the last-grant pointers described above.
- AXIL_ARB_RR_EN undefined: fixed priority, master 0 always wins a tie. The pointer registers are not built.

## Test plan
- Single write, master 1: awaddr=0x0010, wdata=0xDEADBEEF, wstrb=0xF. Target sees AW and W in cycle 1. s_axil_bvalid=2'b10 with bresp=0. s_axil_awready[0] stays 0 throughout.
- Simultaneous write requests from both masters, repeated 4 times, RR enabled: grant order 0,1,0,1. With RR disabled: master 0 wins every tie while it keeps requesting.
- W before AW: m_axil_wready asserted 3 cycles before m_axil_awready. W completes first, AW follows, then B. Exactly one response is returned to the granted master.
- Concurrent operations: master 0 reads 0x0020 while master 1 writes 0x0020. Both paths complete independently. rdata reaches only s_axil_rvalid[0] and bvalid reaches only s_axil_bvalid[1].
- Back-pressure: s_axil_rready[1]=0 for 5 cycles while m_axil_rvalid=1. m_axil_rready stays 0, rdata is held, and no new AR is issued until the R handshake.
- Reset asserted during W_RESP: all outputs listed under Timing/Reset are 0 on the next cycle. A new write after reset is granted to master 0 first.
